// File: rtl/jtkcpu_busctl.sv
// rtl/jtkcpu_busctl.sv - CPU bus controller with fractional clock enables and req/ack memory port
//
// Generates cen/cen2 for the CPU core and turns every CPU bus cycle into one
// req/ack transaction. The enables freeze while an access is outstanding, so
// slow memory appears to the core as wait states.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   hold              freezes cen/cen2 and defers new accesses (DMA)
//   cpu_addr/we/dout  CPU bus cycle outputs
//   cpu_din           read data returned to the CPU (0xFF on a timed-out read)
//   cen, cen2         CPU clock enables (cen2 at 2*CEN_NUM/CEN_DEN of clk, cen at half that)
//   mem_addr/we/dout  latched access, valid while mem_req is high
//   mem_req           access request level
//   mem_ack, mem_din  one-cycle completion pulse and its read data
//   bus_err           one-cycle pulse when an access times out

module jtkcpu_busctl #(
  parameter int CEN_NUM = 1,
  parameter int CEN_DEN = 4,
  parameter int TOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic [23:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cen,
  output logic        cen2,
  output logic [23:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_dout,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_din,
  output logic        bus_err
);

  localparam logic [8:0] STEP  = 9'(2 * CEN_NUM);
  localparam logic [8:0] DEN   = 9'(CEN_DEN);
  localparam logic [7:0] TLAST = 8'(TOUT - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state_q;
  logic [7:0]  acc_q;
  logic        phase_q;
  logic [7:0]  tcnt_q;
  logic        after_cen_q;
  logic        start_pending_q;
  logic        cen_q, cen2_q, mem_req_q, mem_we_q, bus_err_q;
  logic [7:0]  cpu_din_q, mem_dout_q;
  logic [23:0] mem_addr_q;

  logic [8:0]  nx_d;
  logic        tick_d;
  logic        stalled_d;

  always_comb begin
    nx_d      = {1'b0, acc_q} + STEP;
    tick_d    = (nx_d >= DEN);
    stalled_d = (state_q != ST_IDLE) | hold | start_pending_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      acc_q           <= '0;
      phase_q         <= 1'b0;
      tcnt_q          <= '0;
      after_cen_q     <= 1'b0;
      start_pending_q <= 1'b0;
      cen_q           <= 1'b0;
      cen2_q          <= 1'b0;
      cpu_din_q       <= '0;
      mem_addr_q      <= '0;
      mem_we_q        <= 1'b0;
      mem_dout_q      <= '0;
      mem_req_q       <= 1'b0;
      bus_err_q       <= 1'b0;
    end else begin
      cen_q       <= 1'b0;
      cen2_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      // The core updates its bus outputs on the cen edge, so they are
      // sampled one cycle after the cen pulse is seen.
      after_cen_q <= cen_q;

      // A stalled tick leaves acc untouched so it fires again as soon as
      // the stall clears; missed ticks are simply dropped.
      if (!tick_d) begin
        acc_q <= nx_d[7:0];
      end else if (!stalled_d) begin
        acc_q   <= 8'(nx_d - DEN);
        cen2_q  <= 1'b1;
        cen_q   <= phase_q;
        phase_q <= ~phase_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (after_cen_q || start_pending_q) begin
            if (hold) begin
              start_pending_q <= 1'b1;
            end else begin
              start_pending_q <= 1'b0;
              mem_addr_q      <= cpu_addr;
              mem_we_q        <= cpu_we;
              mem_dout_q      <= cpu_dout;
              mem_req_q       <= 1'b1;
              tcnt_q          <= '0;
              state_q         <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            if (!mem_we_q) cpu_din_q <= mem_din;
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (tcnt_q == TLAST) begin
            if (!mem_we_q) cpu_din_q <= 8'hFF;
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cen      = cen_q;
  assign cen2     = cen2_q;
  assign cpu_din  = cpu_din_q;
  assign mem_addr = mem_addr_q;
  assign mem_we   = mem_we_q;
  assign mem_dout = mem_dout_q;
  assign mem_req  = mem_req_q;
  assign bus_err  = bus_err_q;

endmodule
